// File: rtl/data_memory_ctrl_if.sv
// Load/store request and response bus between the core's LSU and the data memory controller.
// The master drives requests; the slave (the controller) returns ready and the response strobe.
interface data_memory_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Single-port byte-lane data memory with sub-word loads/stores, alignment and range checks,
// and a programmable access latency. One request in flight at a time.
module data_memory_ctrl #(
    parameter int DEPTH   = 128,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    data_memory_ctrl_if.slave  bus
);
    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_next;
    logic              w_accept;
    logic              w_enter_resp;

    logic              r_we;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic [31:0]       r_mem [DEPTH] = '{default: '0};

    logic              w_we;
    logic [1:0]        w_size;
    logic              w_uns;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;
    logic [IDX_W-1:0]  w_idx;
    logic [MEM_AW-1:0] w_ram_idx;
    logic [1:0]        w_lane;
    logic              w_oor;
    logic              w_err;
    logic [31:0]       w_rword;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;
    logic [3:0]        w_be;
    logic [31:0]       w_wd;

    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    if (LATENCY > 0) begin
                        w_next     = S_WAIT;
                        w_cnt_next = LAT;
                    end else begin
                        w_next       = S_RESP;
                        w_enter_resp = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_next       = S_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // With zero latency the access happens on the accepting edge, before the latches
    // are loaded, so the request is taken straight from the bus in IDLE.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_we    = bus.req_we;
            w_size  = bus.req_size;
            w_uns   = bus.req_unsigned;
            w_addr  = bus.req_addr;
            w_wdata = bus.req_wdata;
        end else begin
            w_we    = r_we;
            w_size  = r_size;
            w_uns   = r_uns;
            w_addr  = r_addr;
            w_wdata = r_wdata;
        end
    end

    assign w_idx     = w_addr[ADDR_W-1:2];
    assign w_ram_idx = w_idx[MEM_AW-1:0];
    assign w_lane    = w_addr[1:0];
    assign w_oor     = ({1'b0, w_idx} >= (IDX_W + 1)'(DEPTH));
    assign w_err     = (w_size == 2'b11)
                     | ((w_size == 2'b01) & w_addr[0])
                     | ((w_size == 2'b10) & (|w_addr[1:0]))
                     | w_oor;

    assign w_rword = r_mem[w_ram_idx];
    assign w_byte  = w_rword[{w_lane, 3'b000} +: 8];
    assign w_half  = w_lane[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        w_load = '0;
        w_be   = '0;
        w_wd   = '0;
        case (w_size)
            2'b00: begin
                w_load = w_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
                w_be   = 4'b0001 << w_lane;
                w_wd   = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_load = w_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
                w_be   = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wd   = {2{w_wdata[15:0]}};
            end
            2'b10: begin
                w_load = w_rword;
                w_be   = '1;
                w_wd   = w_wdata;
            end
            default: begin
                w_load = '0;
                w_be   = '0;
                w_wd   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_size  <= bus.req_size;
                r_uns   <= bus.req_unsigned;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_we) ? '0 : w_load;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_enter_resp && w_we && !w_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_ram_idx][8*i +: 8] <= w_wd[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: one instance at LATENCY=0 and one at LATENCY=3,
// inputs driven and outputs sampled on the falling clock edge.
module tb_data_memory_ctrl;
    logic clk = 1'b0;
    logic rst0_n;
    logic rst3_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    data_memory_ctrl_if #(.ADDR_W(32)) if0 ();
    data_memory_ctrl_if #(.ADDR_W(32)) if3 ();

    data_memory_ctrl #(.DEPTH(128), .ADDR_W(32), .LATENCY(0)) u_lat0 (
        .clk   (clk),
        .rst_n (rst0_n),
        .bus   (if0.slave)
    );

    data_memory_ctrl #(.DEPTH(128), .ADDR_W(32), .LATENCY(3)) u_lat3 (
        .clk   (clk),
        .rst_n (rst3_n),
        .bus   (if3.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One LATENCY=0 transaction: response one cycle after accept, ready low for exactly that cycle.
    task automatic txn0(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        if0.req_valid    = 1'b1;
        if0.req_we       = we;
        if0.req_size     = size;
        if0.req_unsigned = uns;
        if0.req_addr     = addr;
        if0.req_wdata    = wdata;
        check({tag, "/ready_before"}, 32'(if0.req_ready), 32'd1);
        @(negedge clk);
        if0.req_valid = 1'b0;
        check({tag, "/rsp_valid"}, 32'(if0.rsp_valid), 32'd1);
        check({tag, "/ready_busy"}, 32'(if0.req_ready), 32'd0);
        check({tag, "/rdata"}, if0.rsp_rdata, exp_rdata);
        check({tag, "/err"}, 32'(if0.rsp_err), 32'(exp_err));
        @(negedge clk);
        check({tag, "/ready_after"}, 32'(if0.req_ready), 32'd1);
        check({tag, "/rsp_valid_after"}, 32'(if0.rsp_valid), 32'd0);
    endtask

    // Generic LATENCY=3 transaction with a bounded wait for the response.
    task automatic txn3(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        bit got;
        if3.req_valid    = 1'b1;
        if3.req_we       = we;
        if3.req_size     = size;
        if3.req_unsigned = uns;
        if3.req_addr     = addr;
        if3.req_wdata    = wdata;
        @(negedge clk);
        if3.req_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (if3.rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "/rsp_seen"}, 32'(got), 32'd1);
        check({tag, "/rdata"}, if3.rsp_rdata, exp_rdata);
        check({tag, "/err"}, 32'(if3.rsp_err), 32'(exp_err));
        @(negedge clk);
    endtask

    initial begin
        int seen;
        rst0_n           = 1'b0;
        rst3_n           = 1'b0;
        if0.req_valid    = 1'b0;
        if0.req_we       = 1'b0;
        if0.req_size     = 2'b00;
        if0.req_unsigned = 1'b0;
        if0.req_addr     = '0;
        if0.req_wdata    = '0;
        if3.req_valid    = 1'b0;
        if3.req_we       = 1'b0;
        if3.req_size     = 2'b00;
        if3.req_unsigned = 1'b0;
        if3.req_addr     = '0;
        if3.req_wdata    = '0;
        repeat (3) @(negedge clk);
        check("rst/ready0", 32'(if0.req_ready), 32'd1);
        check("rst/valid0", 32'(if0.rsp_valid), 32'd0);
        check("rst/rdata0", if0.rsp_rdata, 32'd0);
        check("rst/err0", 32'(if0.rsp_err), 32'd0);
        check("rst/ready3", 32'(if3.req_ready), 32'd1);
        check("rst/valid3", 32'(if3.rsp_valid), 32'd0);
        rst0_n = 1'b1;
        rst3_n = 1'b1;
        @(negedge clk);

        // LATENCY=0: word, byte and half stores/loads
        txn0("sw_10",  1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
        txn0("lw_10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
        txn0("sb_12",  1'b1, 2'b00, 1'b0, 32'h12, 32'h80,       32'h0,        1'b0);
        txn0("lb_12",  1'b0, 2'b00, 1'b0, 32'h12, 32'h0,        32'hFFFFFF80, 1'b0);
        txn0("lbu_12", 1'b0, 2'b00, 1'b1, 32'h12, 32'h0,        32'h00000080, 1'b0);
        txn0("lbu_11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0,        32'h000000BE, 1'b0);
        txn0("lw_10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDE80BEEF, 1'b0);
        txn0("sh_16",  1'b1, 2'b01, 1'b0, 32'h16, 32'h8001,     32'h0,        1'b0);
        txn0("lh_16",  1'b0, 2'b01, 1'b0, 32'h16, 32'h0,        32'hFFFF8001, 1'b0);
        txn0("lhu_16", 1'b0, 2'b01, 1'b1, 32'h16, 32'h0,        32'h00008001, 1'b0);
        txn0("lw_14",  1'b0, 2'b10, 1'b0, 32'h14, 32'h0,        32'h80010000, 1'b0);
        txn0("lh_14",  1'b0, 2'b01, 1'b0, 32'h14, 32'h0,        32'h00000000, 1'b0);
        txn0("lb_17",  1'b0, 2'b00, 1'b0, 32'h17, 32'h0,        32'hFFFFFF80, 1'b0);

        // Errors: word 0 holds a known value that an aliased out-of-range store would clobber
        txn0("sw_00",   1'b1, 2'b10, 1'b0, 32'h00,  32'hCAFEF00D, 32'h0, 1'b0);
        txn0("e_lh_11", 1'b0, 2'b01, 1'b0, 32'h11,  32'h0,        32'h0, 1'b1);
        txn0("e_lw_12", 1'b0, 2'b10, 1'b0, 32'h12,  32'h0,        32'h0, 1'b1);
        txn0("e_sz11",  1'b0, 2'b11, 1'b0, 32'h00,  32'h0,        32'h0, 1'b1);
        txn0("e_sw_oor",1'b1, 2'b10, 1'b0, 32'h200, 32'h12345678, 32'h0, 1'b1);
        txn0("lw_00",   1'b0, 2'b10, 1'b0, 32'h00,  32'h0,        32'hCAFEF00D, 1'b0);
        txn0("lw_1fc",  1'b0, 2'b10, 1'b0, 32'h1FC, 32'h0,        32'h0, 1'b0);

        // LATENCY=3: exact response and re-accept timing with req_valid held high
        txn3("l3_sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h13579BDF, 32'h0, 1'b0);
        if3.req_valid    = 1'b1;
        if3.req_we       = 1'b0;
        if3.req_size     = 2'b10;
        if3.req_unsigned = 1'b0;
        if3.req_addr     = 32'h10;
        check("l3/ready_t", 32'(if3.req_ready), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("l3/no_valid_t+%0d", k), 32'(if3.rsp_valid), 32'd0);
            check($sformatf("l3/busy_t+%0d", k), 32'(if3.req_ready), 32'd0);
        end
        @(negedge clk);
        check("l3/valid_t+4", 32'(if3.rsp_valid), 32'd1);
        check("l3/busy_t+4", 32'(if3.req_ready), 32'd0);
        check("l3/rdata_t+4", if3.rsp_rdata, 32'h13579BDF);
        @(negedge clk);
        check("l3/valid_t+5", 32'(if3.rsp_valid), 32'd0);
        check("l3/ready_t+5", 32'(if3.req_ready), 32'd1);
        @(negedge clk);
        if3.req_valid = 1'b0;
        check("l3/reaccept_t+6", 32'(if3.req_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("l3/second_valid", 32'(if3.rsp_valid), 32'd1);
        check("l3/second_rdata", if3.rsp_rdata, 32'h13579BDF);
        @(negedge clk);

        // LATENCY=3: reset during WAIT drops the store and its response
        if3.req_valid = 1'b1;
        if3.req_we    = 1'b1;
        if3.req_size  = 2'b10;
        if3.req_addr  = 32'h20;
        if3.req_wdata = 32'h55AA55AA;
        @(negedge clk);
        if3.req_valid = 1'b0;
        @(negedge clk);
        rst3_n = 1'b0;
        @(negedge clk);
        rst3_n = 1'b1;
        check("rst3/ready", 32'(if3.req_ready), 32'd1);
        check("rst3/valid", 32'(if3.rsp_valid), 32'd0);
        check("rst3/rdata", if3.rsp_rdata, 32'd0);
        check("rst3/err", 32'(if3.rsp_err), 32'd0);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (if3.rsp_valid) seen++;
            @(negedge clk);
        end
        check("rst3/no_rsp", 32'(seen), 32'd0);
        txn3("rst3/lw_20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
        txn3("rst3/lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h13579BDF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
